// File: rtl/lbm_grid_scanner_pkg.sv
// lbm_grid_scanner_pkg: lattice constants and shared types for the grid scanner
package lbm_grid_scanner_pkg;
   localparam int GRID_NX = 16;
   localparam int GRID_NY = 16;
   localparam int GRID_XW = $clog2(GRID_NX * GRID_NY);
   localparam int GRID_YW = $clog2(GRID_NY);
   typedef enum logic [1:0] {IDLE, SCAN, DONE} scan_state_t;
   typedef struct packed {
      logic [GRID_XW-1:0] x;
      logic [GRID_YW-1:0] y;
   } cell_coord_t;
endpackage

// File: rtl/lbm_grid_scanner_if.sv
// lbm_grid_scanner_if: valid/ready cell-coordinate stream from scanner to per-cell pipeline
interface lbm_grid_scanner_if import lbm_grid_scanner_pkg::*; #(
   parameter int NX  = GRID_NX,
   parameter int NY  = GRID_NY,
   parameter int X_W = $clog2(NX * NY),
   parameter int Y_W = $clog2(NY),
   parameter int A_W = $clog2(NX * NY)
);
   logic           out_valid;
   logic           out_ready;
   logic [X_W-1:0] x;
   logic [Y_W-1:0] y;
   logic [A_W-1:0] addr;
   logic           sof;
   logic           eof;
   modport master (output out_valid, x, y, addr, sof, eof, input out_ready);
   modport slave  (input out_valid, x, y, addr, sof, eof, output out_ready);
endinterface

// File: rtl/lbm_grid_scanner_coord_counter.sv
// lbm_coord_counter: x-fastest lattice position counter with linear address and last-cell flag
module lbm_coord_counter import lbm_grid_scanner_pkg::*; #(
   parameter int NX  = GRID_NX,
   parameter int NY  = GRID_NY,
   parameter int X_W = $clog2(NX * NY),
   parameter int Y_W = $clog2(NY),
   parameter int A_W = $clog2(NX * NY)
)(
   input  logic           clk,
   input  logic           reset,
   input  logic           i_clr,
   input  logic           i_en,
   output logic [X_W-1:0] o_x,
   output logic [Y_W-1:0] o_y,
   output logic [A_W-1:0] o_addr,
   output logic           o_last
);
   logic [X_W-1:0] r_x;
   logic [Y_W-1:0] r_y;
   logic [A_W-1:0] r_addr;
   logic           w_xend;
   assign w_xend = r_x == X_W'(NX - 1);
   assign o_last = w_xend && r_y == Y_W'(NY - 1);
   assign o_x    = r_x;
   assign o_y    = r_y;
   assign o_addr = r_addr;
   // advance one cell per enable, wrapping to the origin after the last cell
   always_ff @(posedge clk) begin
      if (reset || i_clr || (i_en && o_last)) begin
         r_x    <= '0;
         r_y    <= '0;
         r_addr <= '0;
      end else if (i_en) begin
         r_x    <= w_xend ? '0 : r_x + X_W'(1);
         r_y    <= w_xend ? r_y + Y_W'(1) : r_y;
         r_addr <= r_addr + A_W'(1);
      end
   end
endmodule

// File: rtl/lbm_grid_scanner.sv
// lbm_grid_scanner: sweeps the lattice for a latched number of passes over a valid/ready stream
module lbm_grid_scanner import lbm_grid_scanner_pkg::*; #(
   parameter int NX     = GRID_NX,
   parameter int NY     = GRID_NY,
   parameter int X_W    = $clog2(NX * NY),
   parameter int Y_W    = $clog2(NY),
   parameter int A_W    = $clog2(NX * NY),
   parameter int STEP_W = 16
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [STEP_W-1:0] steps,
   lbm_grid_scanner_if.master bus,
   output logic [STEP_W-1:0] pass_cnt,
   output logic              busy,
   output logic              done
);
   scan_state_t       r_state, w_next;
   logic [STEP_W-1:0] r_steps, r_pass;
   logic [X_W-1:0]    w_x;
   logic [Y_W-1:0]    w_y;
   logic [A_W-1:0]    w_addr;
   logic              w_valid, w_last, w_acc, w_wrap, w_final, w_clr, w_go;
   assign w_valid = r_state == SCAN;
   assign w_acc   = w_valid & bus.out_ready;
   assign w_wrap  = w_acc & w_last;
   assign w_final = w_wrap & (r_pass == r_steps - STEP_W'(1));
   assign w_go    = r_state == IDLE & start;
   assign w_clr   = abort | w_go;
   // the final beat of the run leaves the position frozen on the last cell
   lbm_coord_counter #(.NX(NX), .NY(NY), .X_W(X_W), .Y_W(Y_W), .A_W(A_W)) u_coord (
      .clk    (clk),
      .reset  (reset),
      .i_clr  (w_clr),
      .i_en   (w_acc & ~w_final),
      .o_x    (w_x),
      .o_y    (w_y),
      .o_addr (w_addr),
      .o_last (w_last)
   );
   assign bus.out_valid = w_valid;
   assign bus.x         = w_x;
   assign bus.y         = w_y;
   assign bus.addr      = w_addr;
   assign bus.sof       = w_valid & w_x == '0 & w_y == '0;
   assign bus.eof       = w_valid & w_last;
   assign pass_cnt      = r_pass;
   assign busy          = r_state != IDLE;
   assign done          = r_state == DONE;
   // next state: abort wins, a zero-step run goes straight to the done pulse
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = start ? (steps == '0 ? DONE : SCAN) : IDLE;
         SCAN:    w_next = w_final ? DONE : SCAN;
         default: w_next = IDLE;
      endcase
      if (abort) w_next = IDLE;
   end
   // state register
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end
   // pass counter and step count latched on an accepted start
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pass  <= '0;
         r_steps <= '0;
      end else begin
         if (w_clr)                  r_pass <= '0;
         else if (w_wrap & ~w_final) r_pass <= r_pass + STEP_W'(1);
         if (w_go & ~abort) r_steps <= steps;
      end
   end
endmodule

// File: tb/tb_lbm_grid_scanner.sv
// tb_lbm_grid_scanner: directed checks of sweep order, pass wrap, stalls, abort and reset
module tb_lbm_grid_scanner;
   logic        clk = 0;
   logic        reset, start, abort;
   logic [15:0] steps, pass_cnt;
   logic        busy, done;
   int          passed = 0;
   int          total = 0;
   lbm_grid_scanner_if #(.NX(16), .NY(16)) bus ();
   lbm_grid_scanner #(.NX(16), .NY(16)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .abort    (abort),
      .steps    (steps),
      .bus      (bus.master),
      .pass_cnt (pass_cnt),
      .busy     (busy),
      .done     (done)
   );
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask
   task automatic chk_idle_zero(input string tag);
      chk({tag, "_valid"}, 32'(bus.out_valid), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_sof"}, 32'(bus.sof), 0);
      chk({tag, "_eof"}, 32'(bus.eof), 0);
      chk({tag, "_xyap"}, {bus.x, 4'(bus.y), bus.addr, 12'(pass_cnt)}, 0);
   endtask
   task automatic go(input logic [15:0] n);
      steps = n;
      start = 1;
      tick();
      start = 0;
   endtask
   initial begin
      int bad, sofs, eofs, k, cyc;
      logic acc;
      reset = 1; start = 0; abort = 0; steps = 0; bus.out_ready = 1;
      tick(); tick();
      reset = 0;
      chk_idle_zero("reset");
      // 1: single pass, free-flowing; a start with steps=5 mid-run must be ignored
      go(16'd1);
      bad = 0;
      for (int i = 0; i < 256; i++) begin
         if (bus.out_valid !== 1 || bus.x !== 8'(i % 16) || bus.y !== 4'(i / 16) || bus.addr !== 8'(i)
             || bus.sof !== (i == 0) || bus.eof !== (i == 255) || pass_cnt !== 0 || done !== 0) bad++;
         if (i == 10) begin steps = 16'd5; start = 1; end
         tick();
         start = 0;
      end
      chk("t1_stream_errs", bad, 0);
      chk("t1_done", 32'(done), 1);
      chk("t1_valid_off", 32'(bus.out_valid), 0);
      chk("t1_busy_in_done", 32'(busy), 1);
      tick();
      chk("t1_done_pulse", 32'(done), 0);
      chk("t1_busy_off", 32'(busy), 0);
      chk("t1_hold_xy", {bus.x, 4'(bus.y)}, {8'd15, 4'd15});
      chk("t1_hold_addr", 32'(bus.addr), 255);
      // 2: three passes back to back, no bubble at the wrap
      go(16'd3);
      bad = 0; sofs = 0; eofs = 0;
      for (int i = 0; i < 768; i++) begin
         if (bus.out_valid !== 1 || bus.addr !== 8'(i % 256) || pass_cnt !== 16'(i / 256)) bad++;
         sofs += int'(bus.sof);
         eofs += int'(bus.eof);
         tick();
      end
      chk("t2_stream_errs", bad, 0);
      chk("t2_sof_count", sofs, 3);
      chk("t2_eof_count", eofs, 3);
      chk("t2_done", 32'(done), 1);
      chk("t2_last_pass", 32'(pass_cnt), 2);
      tick();
      // 3: random backpressure, every cell exactly once in order, outputs held while stalled
      go(16'd1);
      bad = 0; k = 0; cyc = 0;
      while (!done && cyc < 3000) begin
         if (bus.out_valid && (bus.addr !== 8'(k) || bus.x !== 8'(k % 16) || bus.y !== 4'(k / 16))) bad++;
         bus.out_ready = 1'($urandom_range(0, 1));
         acc = bus.out_valid & bus.out_ready;
         tick();
         if (acc) k++;
         cyc++;
      end
      chk("t3_timeout", 32'(done), 1);
      chk("t3_order_errs", bad, 0);
      chk("t3_beats", k, 256);
      bus.out_ready = 1;
      tick();
      // 4: zero steps, done without any beat
      go(16'd0);
      chk("t4_valid", 32'(bus.out_valid), 0);
      chk("t4_done", 32'(done), 1);
      tick();
      chk("t4_done_pulse", 32'(done), 0);
      chk("t4_valid_after", 32'(bus.out_valid), 0);
      // 5: abort at beat 100, then restart from the origin
      go(16'd1);
      for (int i = 0; i < 100; i++) tick();
      chk("t5_at_beat100", {bus.x, 4'(bus.y)}, {8'd4, 4'd6});
      abort = 1;
      tick();
      abort = 0;
      chk_idle_zero("t5_abort");
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (done !== 0 || bus.out_valid !== 0) bad++;
      end
      chk("t5_no_done", bad, 0);
      go(16'd1);
      chk("t5_restart_valid", 32'(bus.out_valid), 1);
      chk("t5_restart_sof", 32'(bus.sof), 1);
      chk("t5_restart_addr", 32'(bus.addr), 0);
      // 6: stall mid-pass, then reset drops the in-flight beat
      for (int i = 0; i < 40; i++) tick();
      bus.out_ready = 0;
      tick(); tick();
      chk("t6_stall_hold", 32'(bus.addr), 40);
      reset = 1;
      tick();
      reset = 0;
      bus.out_ready = 1;
      chk_idle_zero("t6_reset");
      tick();
      chk("t6_stays_idle", 32'(busy), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
